idex_stage: RTL and testbench

IDEX_STAGE -- requirements
Module: idex_stage

---
 rtl/mips_pkg.sv | 37 +++
 rtl/idex_hazard.sv | 31 +++
 rtl/idex_stage.sv | 102 ++++++++++
 tb/tb_idex_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants, IDEX pipeline record and destination-register decode.
package mips_pkg;

   localparam logic [5:0] ALUop   = 6'h00;
   localparam logic [5:0] Jop     = 6'h02;
   localparam logic [5:0] JALop   = 6'h03;
   localparam logic [5:0] ADD_IMM = 6'h08;
   localparam logic [5:0] LW      = 6'h23;
   localparam logic [5:0] SW      = 6'h2B;

   localparam logic [31:0] NOP      = 32'h0000_0000;
   localparam logic [4:0]  REG_ZERO = 5'd0;
   localparam logic [4:0]  REG_RA   = 5'd31;

   typedef struct packed {
      logic        valid;
      logic [31:0] ir;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
   } idex_t;

   localparam idex_t IDEX_BUBBLE = '{valid: 1'b0, ir: NOP, pc: '0, a: '0, b: '0};

   // Register 0 doubles as "no destination", so hazard logic never needs a separate flag.
   function automatic logic [4:0] dest_reg(input logic [5:0] op, input logic [4:0] rt,
                                           input logic [4:0] rd);
      case (op)
         ALUop:       dest_reg = rd;
         LW, ADD_IMM: dest_reg = rt;
         JALop:       dest_reg = REG_RA;
         SW, Jop:     dest_reg = REG_ZERO;
         default:     dest_reg = REG_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/idex_hazard.sv
// Load-use interlock: decodes the IDEX destination and compares it against the decode sources.
// With MIPS_FWD_EN only loads interlock; otherwise every writing instruction does.
module idex_hazard
   import mips_pkg::*;
(
   input  logic       ex_valid,
   input  logic [5:0] idex_op,
   input  logic [4:0] idex_rt,
   input  logic [4:0] idex_rd,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   output logic       stall
);

   logic [4:0] dest;
   logic       writer_ok;

   assign dest = dest_reg(idex_op, idex_rt, idex_rd);

`ifdef MIPS_FWD_EN
   assign writer_ok = (idex_op == LW);
`else
   // A non-zero destination already implies a writing opcode.
   assign writer_ok = 1'b1;
`endif

   assign stall = ex_valid & id_valid & writer_ok & (dest != REG_ZERO)
                & ((dest == id_rs) | (dest == id_rt));

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and backpressure.
// Optional feature macro: MIPS_FWD_EN adds EX/MEM operand forwarding and the exmem_* ports.
module idex_stage
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [31:0] id_ir,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_a,
   input  logic [31:0] id_b,
   input  logic        ex_ready,
   input  logic        flush,
`ifdef MIPS_FWD_EN
   input  logic [4:0]  exmem_rd,
   input  logic        exmem_wr,
   input  logic [31:0] exmem_res,
`endif
   output logic        id_ready,
   output logic        ex_valid,
   output logic [31:0] idex_ir,
   output logic [31:0] idex_pc,
   output logic [31:0] idex_a,
   output logic [31:0] idex_b,
   output logic [5:0]  op,
   output logic [5:0]  aop,
   output logic        stall
);

   idex_t       idex_reg;
   idex_t       idex_next;
   logic [31:0] opnd_id  [2];
   logic [31:0] opnd_sel [2];

   assign opnd_id[0] = id_a;
   assign opnd_id[1] = id_b;

`ifdef MIPS_FWD_EN
   logic [4:0] opnd_src [2];
   assign opnd_src[0] = id_ir[25:21];
   assign opnd_src[1] = id_ir[20:16];
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
`ifdef MIPS_FWD_EN
         assign opnd_sel[gi] = (exmem_wr && (exmem_rd != REG_ZERO) && (exmem_rd == opnd_src[gi]))
                             ? exmem_res : opnd_id[gi];
`else
         assign opnd_sel[gi] = opnd_id[gi];
`endif
      end
   endgenerate

   idex_hazard u_hazard (
      .ex_valid (idex_reg.valid),
      .idex_op  (idex_reg.ir[31:26]),
      .idex_rt  (idex_reg.ir[20:16]),
      .idex_rd  (idex_reg.ir[15:11]),
      .id_valid (id_valid),
      .id_rs    (id_ir[25:21]),
      .id_rt    (id_ir[20:16]),
      .stall    (stall)
   );

   assign id_ready = ex_ready & ~stall;

   // A stalled or flushed accept still advances EX, so a bubble goes in behind it.
   always_comb begin
      idex_next = idex_reg;
      if (ex_ready) begin
         if (flush || stall) begin
            idex_next = IDEX_BUBBLE;
         end else begin
            idex_next.valid = id_valid;
            idex_next.ir    = id_ir;
            idex_next.pc    = id_pc;
            idex_next.a     = opnd_sel[0];
            idex_next.b     = opnd_sel[1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_reg <= IDEX_BUBBLE;
      end else begin
         idex_reg <= idex_next;
      end
   end

   assign ex_valid = idex_reg.valid;
   assign idex_ir  = idex_reg.ir;
   assign idex_pc  = idex_reg.pc;
   assign idex_a   = idex_reg.a;
   assign idex_b   = idex_reg.b;
   assign op       = idex_reg.ir[31:26];
   assign aop      = idex_reg.ir[5:0];

endmodule

// File: tb/tb_idex_stage.sv
// Directed and randomized bench for idex_stage against a behavioural pipeline-register model.
// Covers MIPS_FWD_EN forwarding when the macro is defined for the build.
module tb_idex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_ir, id_pc, id_a, id_b;
   logic        ex_ready, flush;
   logic        id_ready, ex_valid, stall;
   logic [31:0] idex_ir, idex_pc, idex_a, idex_b;
   logic [5:0]  op, aop;
`ifdef MIPS_FWD_EN
   logic [4:0]  exmem_rd;
   logic        exmem_wr;
   logic [31:0] exmem_res;
`endif

   int checks = 0;
   int errors = 0;

   // Behavioural model of what IDEX should hold.
   logic        m_valid;
   logic [31:0] m_ir, m_pc, m_a, m_b;

   always #5 clk = ~clk;

   idex_stage dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .id_valid (id_valid),
      .id_ir    (id_ir),
      .id_pc    (id_pc),
      .id_a     (id_a),
      .id_b     (id_b),
      .ex_ready (ex_ready),
      .flush    (flush),
`ifdef MIPS_FWD_EN
      .exmem_rd (exmem_rd),
      .exmem_wr (exmem_wr),
      .exmem_res(exmem_res),
`endif
      .id_ready (id_ready),
      .ex_valid (ex_valid),
      .idex_ir  (idex_ir),
      .idex_pc  (idex_pc),
      .idex_a   (idex_a),
      .idex_b   (idex_b),
      .op       (op),
      .aop      (aop),
      .stall    (stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
      return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] opc, input int rs, input int rt,
                                         input logic [15:0] imm);
      return {opc, rs[4:0], rt[4:0], imm};
   endfunction

   // Which register an instruction writes; 0 means it writes nothing.
   function automatic logic [4:0] tb_dest(input logic [31:0] ir);
      case (ir[31:26])
         6'h00:        return ir[15:11];
         6'h23, 6'h08: return ir[20:16];
         6'h03:        return 5'd31;
         default:      return 5'd0;
      endcase
   endfunction

   function automatic logic model_stall();
      logic [4:0] d;
      d = tb_dest(m_ir);
      if (!m_valid || !id_valid || d == 5'd0) return 1'b0;
      if (d != id_ir[25:21] && d != id_ir[20:16]) return 1'b0;
`ifdef MIPS_FWD_EN
      return m_ir[31:26] == 6'h23;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [31:0] model_opnd(input logic [4:0] src, input logic [31:0] val);
`ifdef MIPS_FWD_EN
      if (exmem_wr && exmem_rd != 5'd0 && exmem_rd == src) return exmem_res;
`endif
      return val;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_ir = '0; m_pc = '0; m_a = '0; m_b = '0;
   endtask

   task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic rdy, input logic fl);
      id_valid = v; id_ir = ir; id_pc = pc; id_a = a; id_b = b;
      ex_ready = rdy; flush = fl;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, m_valid});
      chk({tag, ".idex_ir"}, idex_ir, m_ir);
      chk({tag, ".idex_pc"}, idex_pc, m_pc);
      chk({tag, ".idex_a"}, idex_a, m_a);
      chk({tag, ".idex_b"}, idex_b, m_b);
      chk({tag, ".op"}, {26'd0, op}, {26'd0, m_ir[31:26]});
      chk({tag, ".aop"}, {26'd0, aop}, {26'd0, m_ir[5:0]});
   endtask

   // One clock: check combinational outputs, take the edge, advance the model, check registers.
   task automatic cycle(input string tag);
      logic s;
      #1;
      s = model_stall();
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
      chk({tag, ".id_ready"}, {31'd0, id_ready}, {31'd0, ex_ready & ~s});
      @(posedge clk);
      if (ex_ready) begin
         if (flush || s) begin
            model_reset();
         end else begin
            m_valid = id_valid; m_ir = id_ir; m_pc = id_pc;
            m_a = model_opnd(id_ir[25:21], id_a);
            m_b = model_opnd(id_ir[20:16], id_b);
         end
      end
      #1;
      check_regs(tag);
   endtask

   initial begin
      logic [5:0]  opc_tbl [7];
      logic [31:0] held_ir;
      opc_tbl = '{6'h00, 6'h23, 6'h08, 6'h03, 6'h02, 6'h2B, 6'h0C};

      rst_n = 1'b0;
      drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
`ifdef MIPS_FWD_EN
      exmem_rd = '0; exmem_wr = 1'b0; exmem_res = '0;
`endif
      model_reset();
      #1;
      check_regs("reset");
      chk("reset.stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load-use: LW $5 then ADD $6,$5,$7 gets exactly one bubble.
      drive(1'b1, itype(6'h23, 1, 5, 16'h0010), 32'h100, 32'h11, 32'h22, 1'b1, 1'b0);
      cycle("lu_lw");
      drive(1'b1, rtype(5, 7, 6), 32'h104, 32'h33, 32'h44, 1'b1, 1'b0);
      #1;
      chk("lu.stall_hi", {31'd0, stall}, 32'd1);
      chk("lu.id_ready_lo", {31'd0, id_ready}, 32'd0);
      cycle("lu_bubble");
      chk("lu.bubble_valid", {31'd0, ex_valid}, 32'd0);
      chk("lu.bubble_ir", idex_ir, 32'd0);
      cycle("lu_capture");
      chk("lu.add_valid", {31'd0, ex_valid}, 32'd1);
      chk("lu.add_ir", idex_ir, rtype(5, 7, 6));

      // Independent ADD behind a load goes straight through.
      drive(1'b1, itype(6'h23, 1, 5, 16'h0020), 32'h200, 32'h1, 32'h2, 1'b1, 1'b0);
      cycle("nc_lw");
      drive(1'b1, rtype(8, 9, 6), 32'h204, 32'h55, 32'h66, 1'b1, 1'b0);
      cycle("nc_add");
      chk("nc.add_ir", idex_ir, rtype(8, 9, 6));
      chk("nc.add_b", idex_b, 32'h66);

      // Flush while stalled loads a bubble.
      drive(1'b1, itype(6'h23, 2, 5, 16'h0030), 32'h300, 32'h7, 32'h8, 1'b1, 1'b0);
      cycle("fl_lw");
      drive(1'b1, rtype(7, 5, 6), 32'h304, 32'h9, 32'hA, 1'b1, 1'b1);
      cycle("fl_stall");
      chk("fl.bubble_valid", {31'd0, ex_valid}, 32'd0);

      // Backpressure for three cycles, one of them with flush; flush taken once ready returns.
      drive(1'b1, rtype(1, 2, 3), 32'h400, 32'hAAAA, 32'hBBBB, 1'b1, 1'b0);
      cycle("bp_load");
      held_ir = rtype(1, 2, 3);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, rtype(9, 10, 11), 32'h404 + i, 32'h1 + i, 32'h2 + i, 1'b0, i == 1);
         cycle("bp_hold");
         chk("bp.id_ready_lo", {31'd0, id_ready}, 32'd0);
         chk("bp.ir_held", idex_ir, held_ir);
      end
      drive(1'b1, rtype(9, 10, 11), 32'h408, 32'h1, 32'h2, 1'b1, 1'b1);
      cycle("bp_flush");
      chk("bp.flush_valid", {31'd0, ex_valid}, 32'd0);

`ifdef MIPS_FWD_EN
      drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
      cycle("fwd_idle");
      exmem_rd = 5'd5; exmem_wr = 1'b1; exmem_res = 32'hDEADBEEF;
      drive(1'b1, rtype(5, 6, 7), 32'h500, 32'h1234, 32'h5678, 1'b1, 1'b0);
      cycle("fwd");
      chk("fwd.idex_a", idex_a, 32'hDEADBEEF);
      chk("fwd.idex_b", idex_b, 32'h5678);
      exmem_wr = 1'b0;
`endif

      // Randomized traffic with small register numbers so hazards are frequent.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] ir;
         ir = $urandom;
         ir[31:26] = opc_tbl[$urandom_range(0, 6)];
         ir[25:21] = 5'($urandom_range(0, 7));
         ir[20:16] = 5'($urandom_range(0, 7));
         ir[15:11] = 5'($urandom_range(0, 7));
`ifdef MIPS_FWD_EN
         exmem_rd = 5'($urandom_range(0, 7)); exmem_wr = 1'($urandom); exmem_res = $urandom;
`endif
         drive($urandom_range(0, 9) < 8, ir, $urandom, $urandom, $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
         cycle("rand");
      end

      // Reset mid-stall drops the stalled load and releases stall immediately.
      drive(1'b1, itype(6'h23, 1, 5, 16'h0040), 32'h600, 32'h1, 32'h2, 1'b1, 1'b0);
      cycle("rs_lw");
      drive(1'b1, rtype(5, 7, 6), 32'h604, 32'h3, 32'h4, 1'b1, 1'b0);
      #1;
      chk("rs.stall_hi", {31'd0, stall}, 32'd1);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_regs("rs_async");
      chk("rs.stall_lo", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle("rs_after");
      chk("rs.add_ir", idex_ir, rtype(5, 7, 6));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
